// File: rtl/trail_manager.sv
// Per-core assignment trail stack: records each assignment in push order and
// unwinds entries above a target decision level one per cycle on backtrack.
module trail_manager #(
   parameter int DEPTH = 4,
   parameter int LVL_W = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_valid,
   output logic               push_ready,
   input  logic [32+LVL_W:0]  push_entry,
   input  logic               bt_req,
   input  logic [LVL_W-1:0]   bt_level,
   output logic               bt_busy,
   output logic               bt_done,
   output logic               undo_valid,
   output logic [32+LVL_W:0]  undo_entry,
   input  logic               undo_ready,
   output logic [CNT_W-1:0]   count,
   output logic               empty,
   output logic               full,
   output logic [LVL_W-1:0]   cur_level,
   output logic               level_err,
   output logic               ovf_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic signed [31:0] literal;
      logic [LVL_W-1:0]   level;
      logic               is_forced;
   } trail_entry_t;

   typedef enum logic [1:0] {IDLE, BACKTRACK, DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] count_reg;
   logic [LVL_W-1:0] lvl_reg;
   logic             run_reg;
   logic             level_err_reg;
   logic             ovf_err_reg;

   trail_entry_t     entry_mem [DEPTH];
   trail_entry_t     push_e;
   trail_entry_t     top_e;
   logic [IDX_W-1:0] top_idx;
   logic [DEPTH-1:0] wr_en;
   logic             push_fire;
   logic             pop_fire;

   assign push_e  = push_entry;
   assign top_idx = IDX_W'(count_reg - CNT_W'(1));
   assign top_e   = entry_mem[top_idx];

   always_comb begin
      empty      = (count_reg == '0);
      full       = (count_reg == CNT_W'(DEPTH));
      count      = count_reg;
      cur_level  = empty ? '0 : top_e.level;
      // run_reg holds push_ready low until the first clock after reset release
      push_ready = run_reg && (state_reg == IDLE) && !full && !bt_req;
      push_fire  = push_valid && push_ready;
      undo_valid = (state_reg == BACKTRACK) && !empty && (top_e.level > lvl_reg);
      undo_entry = ((state_reg == BACKTRACK) && !empty) ? top_e : '0;
      pop_fire   = undo_valid && undo_ready;
      bt_busy    = (state_reg != IDLE);
      bt_done    = (state_reg == DONE);
      level_err  = level_err_reg;
      ovf_err    = ovf_err_reg;
   end

   // One-hot write enable: an accepted push lands in the slot just above the top
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr
         assign wr_en[gi] = push_fire && (count_reg == CNT_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) entry_mem[i] <= push_e;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         lvl_reg       <= '0;
         run_reg       <= 1'b0;
         level_err_reg <= 1'b0;
         ovf_err_reg   <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (push_fire) begin
                  count_reg <= count_reg + CNT_W'(1);
                  if (!empty && (push_e.level < cur_level)) level_err_reg <= 1'b1;
               end
               if (push_valid && full) ovf_err_reg <= 1'b1;
               if (bt_req) begin
                  lvl_reg   <= bt_level;
                  state_reg <= BACKTRACK;
               end
            end
            BACKTRACK: begin
               if (undo_valid) begin
                  if (pop_fire) count_reg <= count_reg - CNT_W'(1);
               end else begin
                  state_reg <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trail_manager.sv
// Directed bench for trail_manager: a model stack predicts pops into a scoreboard
// queue that is drained as the DUT presents undo entries.
module tb_trail_manager;

   logic        clk;
   logic        rst_n;
   logic        push_valid;
   logic        push_ready;
   logic [36:0] push_entry;
   logic        bt_req;
   logic [3:0]  bt_level;
   logic        bt_busy;
   logic        bt_done;
   logic        undo_valid;
   logic [36:0] undo_entry;
   logic        undo_ready;
   logic [2:0]  count;
   logic        empty;
   logic        full;
   logic [3:0]  cur_level;
   logic        level_err;
   logic        ovf_err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [36:0] trail_q [$];
   logic [36:0] exp_q [$];
   bit          exp_lerr = 0;
   bit          exp_ovf  = 0;

   trail_manager #(.DEPTH(4), .LVL_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_valid(push_valid), .push_ready(push_ready), .push_entry(push_entry),
      .bt_req(bt_req), .bt_level(bt_level), .bt_busy(bt_busy), .bt_done(bt_done),
      .undo_valid(undo_valid), .undo_entry(undo_entry), .undo_ready(undo_ready),
      .count(count), .empty(empty), .full(full), .cur_level(cur_level),
      .level_err(level_err), .ovf_err(ovf_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [36:0] mk(input int lit, input int lvl, input bit f);
      logic [31:0] l32;
      logic [3:0]  v4;
      l32 = lit;
      v4  = lvl[3:0];
      return {l32, v4, f};
   endfunction

   function automatic logic [3:0] model_level();
      logic [36:0] t;
      if (trail_q.size() == 0) return 4'd0;
      t = trail_q[$];
      return t[4:1];
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"}, count, trail_q.size());
      chk({tag, "_cur_level"}, cur_level, model_level());
      chk({tag, "_empty"}, empty, trail_q.size() == 0);
      chk({tag, "_full"}, full, trail_q.size() == 4);
      chk({tag, "_level_err"}, level_err, exp_lerr);
      chk({tag, "_ovf_err"}, ovf_err, exp_ovf);
   endtask

   task automatic do_push(input logic [36:0] e);
      bit acc;
      logic [3:0] lv;
      lv = e[4:1];
      acc = (trail_q.size() < 4);
      push_valid = 1;
      push_entry = e;
      @(negedge clk);
      chk("push_ready", push_ready, acc);
      if (!acc) exp_ovf = 1;
      if (acc && trail_q.size() > 0 && lv < model_level()) exp_lerr = 1;
      if (acc) trail_q.push_back(e);
      next_cyc();
      push_valid = 0;
   endtask

   task automatic do_bt(input logic [3:0] lvl, input bit toggle);
      int  n;
      bit  done;
      logic [36:0] t;
      done = 0;
      forever begin
         if (trail_q.size() == 0) break;
         t = trail_q[$];
         if (t[4:1] <= lvl) break;
         exp_q.push_back(trail_q.pop_back());
      end
      n = exp_q.size();
      bt_req   = 1;
      bt_level = lvl;
      @(negedge clk);
      chk("bt_blocks_push", push_ready, 0);
      next_cyc();
      bt_req     = 0;
      push_valid = 0;
      bt_level   = 4'($urandom_range(0, 15));
      for (int c = 1; c <= 40 && !done; c++) begin
         undo_ready = toggle ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         if (bt_done) begin
            done = 1;
            if (!toggle) chk("bt_done_cycle", c, n + 2);
            chk("undo_all_seen", exp_q.size(), 0);
         end else begin
            chk("bt_busy", bt_busy, 1);
            if (!toggle) chk("undo_valid", undo_valid, c <= n);
            if (undo_valid) begin
               if (exp_q.size() == 0) begin
                  chk("undo_unexpected", undo_valid, 0);
               end else begin
                  chk("undo_entry", undo_entry, exp_q[0]);
                  $display("undo c=%0d entry=%0h ready=%0b", c, undo_entry, undo_ready);
                  if (undo_ready) void'(exp_q.pop_front());
               end
            end
         end
         next_cyc();
      end
      if (!done) chk("bt_timeout", done, 1);
      undo_ready = 0;
      exp_q.delete();
      @(negedge clk);
      chk("bt_idle_busy", bt_busy, 0);
      chk("bt_idle_done", bt_done, 0);
      check_state("after_bt");
      $display("backtrack to L%0d: %0d pops, count=%0d", lvl, n, count);
      next_cyc();
   endtask

   initial begin
      rst_n = 0; push_valid = 0; push_entry = '0;
      bt_req = 0; bt_level = '0; undo_ready = 0;
      #3;
      chk("rst_push_ready", push_ready, 0);
      chk("rst_bt_busy", bt_busy, 0);
      chk("rst_bt_done", bt_done, 0);
      chk("rst_undo_valid", undo_valid, 0);
      chk("rst_undo_entry", undo_entry, 0);
      check_state("rst");
      next_cyc();
      next_cyc();
      rst_n = 1;
      next_cyc();

      // Fill the trail, then one overflow push
      do_push(mk(1, 0, 0));
      do_push(mk(-2, 1, 0));
      do_push(mk(3, 1, 1));
      do_push(mk(-4, 2, 0));
      @(negedge clk);
      check_state("filled");
      next_cyc();
      do_push(mk(5, 2, 0));
      @(negedge clk);
      check_state("overflow");
      next_cyc();

      // Backtrack to level 0: -4, +3, -2
      do_bt(4'd0, 0);

      // Rebuild, backtrack to level 1 with stalling consumer
      do_push(mk(-2, 1, 0));
      do_push(mk(3, 1, 1));
      do_push(mk(-4, 2, 0));
      do_bt(4'd1, 1);

      // Level above current: no pops
      do_push(mk(-4, 2, 1));
      do_bt(4'd3, 0);

      // Backtrack to level 1 then bt_req colliding with a push
      do_bt(4'd1, 0);
      push_valid = 1;
      push_entry = mk(9, 1, 0);
      do_bt(4'd1, 0);

      // Out-of-order level push sets sticky level_err
      do_bt(4'd0, 0);
      do_push(mk(-2, 2, 0));
      @(negedge clk);
      check_state("pre_lerr");
      next_cyc();
      do_push(mk(3, 1, 0));
      @(negedge clk);
      check_state("lerr_set");
      next_cyc();
      do_push(mk(7, 1, 1));
      @(negedge clk);
      check_state("lerr_sticky");
      next_cyc();

      // Reset in the middle of a backtrack after one pop
      bt_req = 1;
      bt_level = 4'd0;
      next_cyc();
      bt_req = 0;
      undo_ready = 1;
      @(negedge clk);
      chk("mid_undo_entry", undo_entry, trail_q[$]);
      void'(trail_q.pop_back());
      next_cyc();
      @(negedge clk);
      chk("mid_busy", bt_busy, 1);
      chk("mid_count", count, trail_q.size());
      rst_n = 0;
      #1;
      trail_q.delete();
      exp_lerr = 0;
      exp_ovf  = 0;
      chk("rst2_push_ready", push_ready, 0);
      chk("rst2_bt_busy", bt_busy, 0);
      chk("rst2_bt_done", bt_done, 0);
      chk("rst2_undo_valid", undo_valid, 0);
      chk("rst2_undo_entry", undo_entry, 0);
      check_state("rst2");
      undo_ready = 0;
      next_cyc();
      rst_n = 1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("no_done_after_rst", bt_done, 0);
         chk("idle_after_rst", bt_busy, 0);
         next_cyc();
      end

      // Backtrack on an empty trail
      do_bt(4'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/trail_manager.md
Name: trail_manager

Overview:
- Per-core assignment trail stack holding trail_entry_t records (literal, decision level, is_forced) from the satswarmv2_pkg types.
- Sits directly downstream of the decision/propagation stage, which pushes each new assignment (decision, implication or neighbour-forced divergence).
- On a backtrack request it pops every entry above the target level, one per cycle, and streams each literal to the variable-metadata unassign logic.
- Reports the current decision level and occupancy to the controller.

Parameters:
DEPTH, VAR_MAX (4), maximum trail entries; one per variable.
LVL_W, DECLEVEL_W (4), decision-level width.
CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
push_valid  input  1  push request
push_ready  output  1  push accepted when push_valid && push_ready
push_entry  input  37  trail_entry_t {literal[31:0] signed, level[3:0], is_forced}
bt_req  input  1  backtrack request; sampled only in IDLE
bt_level  input  LVL_W  target level; keep entries with level <= bt_level
bt_busy  output  1  high in BACKTRACK or DONE
bt_done  output  1  one-cycle completion pulse
undo_valid  output  1  popped entry is presented
undo_entry  output  37  top trail_entry_t being undone
undo_ready  input  1  consumer has unassigned the variable
count  output  CNT_W  current occupancy
empty  output  1  count == 0
full  output  1  count == DEPTH
cur_level  output  LVL_W  level of the top entry; 0 when empty
level_err  output  1  sticky: a push carried a level lower than cur_level
ovf_err  output  1  sticky: push_valid seen while full in IDLE

Behaviour:
- Storage: register array of DEPTH entries plus a count pointer. The top entry is at index count-1.
- Reset (asynchronous, rst_n low):
  - count = 0 and FSM state = IDLE.
  - All outputs 0: push_ready, bt_busy, bt_done, undo_valid, undo_entry, cur_level, level_err, ovf_err.
  - Reset mid-backtrack abandons the operation immediately, with no bt_done.
- FSM has three states: IDLE, BACKTRACK, DONE.
- IDLE:
  - push_ready = !full && !bt_req. A backtrack request in the same cycle blocks the push.
  - An accepted push writes entry[count] and increments count at the clock edge.
  - push_valid && full sets ovf_err; no write occurs.
  - An accepted push with push_entry.level < cur_level while not empty sets level_err; the entry is still written.
  - bt_req: register bt_level into lvl_q, go to BACKTRACK. bt_level is ignored outside IDLE.
- BACKTRACK:
  - undo_valid = !empty && top.level > lvl_q.
  - undo_entry = top entry, combinational from the array.
  - On undo_valid && undo_ready, count decrements. At most one pop per cycle.
  - undo_entry must stay stable while undo_valid is high and undo_ready is low.
  - When undo_valid evaluates 0 (empty, or top.level <= lvl_q), the next state is DONE.
  - push_ready = 0 throughout.
- DONE: bt_done = 1 for exactly one cycle, then IDLE.
- Latency:
  - bt_req at cycle T gives BACKTRACK at T+1.
  - With N pops and undo_ready always high, the pops occur at T+1..T+N, BACKTRACK is still held at T+N+1 with undo_valid=0, bt_done is high at T+N+2, and IDLE resumes at T+N+3.
  - A zero-pop backtrack gives bt_done at T+2.
- Boundary cases:
  - bt_level >= cur_level: no pops.
  - bt_level = 0: pops all entries at level >= 1; level-0 entries (top-level unit facts) remain.
  - Backtracking when empty: bt_done at T+2.
  - Occupancy never wraps: count stays within 0..DEPTH.
- Outputs cur_level, empty, full and count are combinational from count and the array.
- is_forced is carried through unchanged; it does not affect pop decisions.

Test Plan:
- Reset release, then push lits +1(L0), -2(L1), +3(L1), -4(L2) with push_valid held high -> push_ready high each cycle; count=4, full=1, cur_level=2. A 5th push -> push_ready=0, ovf_err=1, count stays 4.
- From that state, bt_req with bt_level=0, undo_ready=1 -> undo_entry sequence -4, +3, -2 on consecutive cycles; bt_done at T+5; count=1, cur_level=0.
- Same 4-entry trail, bt_level=1, undo_ready toggling 0/1 -> single pop of -4, held stable while undo_ready=0; final count=3, cur_level=1.
- bt_req with bt_level=3 on a trail at cur_level=2 -> no undo_valid; bt_done at T+2; count unchanged. bt_req on an empty trail -> same timing.
- bt_req and push_valid in the same IDLE cycle -> push_ready=0, push not taken, backtrack proceeds. Push level 1 onto a level-2 top -> level_err=1 and stays set, count increments.
- Assert rst_n low mid-BACKTRACK after one pop -> count=0, all outputs 0 immediately, no bt_done after release.
